// File: rtl/dec_rr_arbiter.sv
// Round-robin arbiter over 8 requesters with hold timeout and one-hot grant decode.
// Latency: grant registered one cycle after req is sampled in IDLE; RELEASE+IDLE gap between grants.
// Backpressure: none; a grant is held until done, request withdrawal or timeout.
module dec_rr_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic       gnt_valid,
    output logic [2:0] gnt_idx,
    output logic [7:0] bcode,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RELEASE
    } state_t;

    localparam logic [3:0] CNT_MAX = 4'(TIMEOUT - 1);

    state_t     state;
    logic [2:0] last;
    logic [3:0] cnt;

    logic       pick_vld;
    logic [2:0] pick_idx;
    logic [2:0] cand;

    logic       rel_now;
    logic       to_now;

    // Descending scan so the smallest offset from last+1 wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = 3'd0;
        cand     = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            cand = last + 3'(k) + 3'd1;
            if (req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // A done on the timeout edge counts as a normal release.
    always_comb begin
        to_now  = (cnt == CNT_MAX) && !done;
        rel_now = done || !req[gnt_idx] || (cnt == CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last      <= 3'd7;
            cnt       <= 4'd0;
            gnt_valid <= 1'b0;
            gnt_idx   <= 3'd0;
            bcode     <= 8'h00;
            timeout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    timeout <= 1'b0;
                    if (pick_vld) begin
                        gnt_idx   <= pick_idx;
                        bcode     <= 8'h01 << pick_idx;
                        gnt_valid <= 1'b1;
                        cnt       <= 4'd0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (rel_now) begin
                        last      <= gnt_idx;
                        gnt_valid <= 1'b0;
                        bcode     <= 8'h00;
                        timeout   <= to_now;
                        cnt       <= 4'd0;
                        state     <= RELEASE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                RELEASE: begin
                    timeout <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    gnt_valid <= 1'b0;
                    bcode     <= 8'h00;
                    timeout   <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dec_rr_arbiter.sv
// Scoreboard bench for dec_rr_arbiter: directed scenarios push expected grant/release events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_dec_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic       gnt_valid;
    logic [2:0] gnt_idx;
    logic [7:0] bcode;
    logic       timeout;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    typedef struct {
        bit         is_rel;
        logic [2:0] idx;
        int         val;   // grant: idle gap before it (-1 = any); release: cycles held
        bit         to;
    } ev_t;

    ev_t exp_q[$];

    dec_rr_arbiter #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .bcode     (bcode),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = 8'h00;
        done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic exp_g(input int idx, input int gap);
        ev_t e;
        e.is_rel = 1'b0; e.idx = 3'(idx); e.val = gap; e.to = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic exp_r(input int idx, input int len, input bit to);
        ev_t e;
        e.is_rel = 1'b1; e.idx = 3'(idx); e.val = len; e.to = to;
        exp_q.push_back(e);
    endtask

    // Monitor: detects grant starts and ends, compares them against the queue.
    initial begin
        bit         prev_v;
        int         held;
        int         gap;
        logic [2:0] cur_idx;
        logic [7:0] one;
        ev_t        e;
        prev_v = 1'b0; held = 0; gap = 0; cur_idx = 3'd0; one = 8'h01;
        wait (mon_en);
        forever begin
            @(negedge clk);
            check("bcode_decode", int'(bcode), gnt_valid ? int'(one << gnt_idx) : 0);
            if (timeout && !(prev_v && !gnt_valid))
                check("timeout_outside_release", 1, 0);
            if (gnt_valid && !prev_v) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_grant", int'(gnt_idx), -1);
                end else begin
                    e = exp_q.pop_front();
                    check("grant_kind", int'(e.is_rel), 0);
                    check("grant_idx", int'(gnt_idx), int'(e.idx));
                    check("grant_bcode", int'(bcode), int'(one << e.idx));
                    if (e.val >= 0) check("grant_gap", gap, e.val);
                end
                held    = 1;
                cur_idx = gnt_idx;
            end else if (gnt_valid && prev_v) begin
                held++;
                check("grant_idx_stable", int'(gnt_idx), int'(cur_idx));
            end else if (!gnt_valid && prev_v) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_release", int'(cur_idx), -1);
                end else begin
                    e = exp_q.pop_front();
                    check("release_kind", int'(e.is_rel), 1);
                    check("release_idx", int'(cur_idx), int'(e.idx));
                    check("release_len", held, e.val);
                    check("release_timeout", int'(timeout), int'(e.to));
                end
                gap = 1;
            end else begin
                gap++;
            end
            prev_v = gnt_valid;
        end
    end

    initial begin
        do_reset();
        check("rst_gnt_valid", int'(gnt_valid), 0);
        check("rst_gnt_idx", int'(gnt_idx), 0);
        check("rst_bcode", int'(bcode), 0);
        check("rst_timeout", int'(timeout), 0);
        mon_en = 1'b1;

        // Single requester 0, done after three grant cycles.
        exp_g(0, -1); exp_r(0, 3, 1'b0);
        req = 8'h01;
        tick(); tick(); tick();
        check("grant0_bcode", int'(bcode), 8'h01);
        done = 1'b1;
        tick();
        done = 1'b0; req = 8'h00;
        check("release_bcode_zero", int'(bcode), 0);
        check("release_valid_zero", int'(gnt_valid), 0);
        repeat (3) tick();

        // Full rotation 0..7,0 with done held high.
        do_reset();
        exp_g(0, -1); exp_r(0, 1, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            exp_g(i % 8, 2); exp_r(i % 8, 1, 1'b0);
        end
        req = 8'hFF; done = 1'b1;
        repeat (26) tick();
        req = 8'h00; done = 1'b0;
        repeat (3) tick();

        // Timeout on requester 5, twice, then re-grant after IDLE.
        do_reset();
        exp_g(5, -1); exp_r(5, 4, 1'b1);
        exp_g(5, 2);  exp_r(5, 4, 1'b1);
        req = 8'h20;
        repeat (11) tick();
        req = 8'h00;
        repeat (3) tick();

        // done coincides with the timeout edge: plain release.
        do_reset();
        exp_g(2, -1); exp_r(2, 4, 1'b0);
        req = 8'h04;
        repeat (4) tick();
        done = 1'b1;
        tick();
        done = 1'b0; req = 8'h00;
        repeat (3) tick();

        // last=6, then 0x81 grants 7, withdrawal releases, then wrap to 0.
        do_reset();
        exp_g(6, -1); exp_r(6, 1, 1'b0);
        exp_g(7, 2);  exp_r(7, 3, 1'b0);
        exp_g(0, 2);  exp_r(0, 1, 1'b0);
        req = 8'h40; done = 1'b1;
        tick(); tick();
        req = 8'h00; done = 1'b0;
        tick();
        req = 8'h81;
        tick(); tick(); tick();
        req = 8'h01;
        tick(); tick(); tick();
        done = 1'b1;
        tick();
        done = 1'b0; req = 8'h00;
        repeat (3) tick();

        // Reset in the middle of a grant to 3.
        do_reset();
        exp_g(3, -1); exp_r(3, 2, 1'b0);
        exp_g(3, 1);  exp_r(3, 1, 1'b0);
        req = 8'h08;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_gnt_valid", int'(gnt_valid), 0);
        check("midrst_bcode", int'(bcode), 0);
        check("midrst_timeout", int'(timeout), 0);
        tick();
        done = 1'b1;
        tick();
        done = 1'b0; req = 8'h00;
        repeat (4) tick();

        check("events_left", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dec_rr_arbiter.md
DEC_RR_ARBITER -- requirements
Module: dec_rr_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15, the maximum number of cycles a grant is held; legal range 1..15.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port req, input, 8 bits: request lines; bit i is requester i.
REQ-005 SHALL have port done, input, 1 bit: the current grantee releases the resource.
REQ-006 SHALL have port gnt_valid, output, 1 bit: a grant is active.
REQ-007 SHALL have port gnt_idx, output, 3 bits: binary index of the granted requester.
REQ-008 SHALL have port bcode, output, 8 bits: one-hot decode of gnt_idx (bit gnt_idx set) when gnt_valid=1, else 8'h00.
REQ-009 SHALL have port timeout, output, 1 bit: one-cycle pulse when a grant is force-released.
REQ-010 SHALL drive all outputs directly from registers, with no combinational path from inputs to outputs.

Function
REQ-011 SHALL implement the FSM states IDLE, GRANT and RELEASE.
REQ-012 SHALL hold a 3-bit last pointer (last) and a 4-bit hold counter (cnt).
REQ-013 IDLE, req==0: SHALL stay in IDLE with gnt_valid=0.
REQ-014 IDLE, req!=0: SHALL select the first set bit scanning (last+1) mod 8 upward, wrapping 7->0, then load gnt_idx, set gnt_valid=1, clear cnt to 0 and enter GRANT.
REQ-015 The grant SHALL be visible in the cycle after the edge on which req was sampled nonzero (1-cycle latency).
REQ-016 GRANT: gnt_idx SHALL stay stable and cnt SHALL increment by 1 each cycle.
REQ-017 GRANT exit SHALL occur on the first edge where done=1, or req[gnt_idx]=0, or (cnt==TIMEOUT-1 and done=0); on exit, last takes gnt_idx, gnt_valid clears and the FSM enters RELEASE.
REQ-018 A timeout exit SHALL set timeout=1 for exactly the RELEASE cycle; all other exits SHALL leave timeout=0.
REQ-019 If done=1 and the timeout condition occur on the same edge, SHALL treat it as a normal release with timeout=0.
REQ-020 RELEASE SHALL last exactly one cycle with gnt_valid=0 and bcode=0, then unconditionally enter IDLE.
REQ-021 Consequently, back-to-back grants SHALL be separated by exactly 2 cycles with gnt_valid=0 (RELEASE, IDLE).
REQ-022 Changes to req bits other than req[gnt_idx] during GRANT SHALL have no effect until the next IDLE arbitration.
REQ-023 With TIMEOUT=1, every grant SHALL last exactly 1 cycle unless it is released by done or by withdrawal of the request.
REQ-024 cnt SHALL never exceed TIMEOUT-1.

Reset
REQ-025 On rst=1 at an edge, SHALL set state=IDLE, last=3'd7, cnt=0, gnt_valid=0, gnt_idx=0, bcode=8'h00 and timeout=0.
REQ-026 rst SHALL take priority over all other inputs, including mid-GRANT; the grant drops on that same edge with no RELEASE cycle and no timeout pulse.
REQ-027 The first arbitration after reset SHALL begin its scan at index 0.

Verification
REQ-028 Reset then req=8'h01, done=1 after 3 cycles: SHALL give gnt_idx=0, bcode=8'h01 one cycle after req; release on the done edge; bcode=8'h00 in RELEASE.
REQ-029 Round-robin with req=8'hFF held and done pulsed each grant: SHALL grant indices 0,1,2,...,7,0 in order with a 2-cycle gap between grants.
REQ-030 Timeout with TIMEOUT=4, req=8'h20 held and done=0: SHALL hold gnt_idx=5, bcode=8'h20 for 4 cycles, then timeout=1 for 1 cycle; requester 5 is re-granted after IDLE.
REQ-031 Simultaneous events with TIMEOUT=4 and done=1 on the 4th grant cycle: SHALL release with timeout=0.
REQ-032 Withdrawal and wrap with last=6, req=8'h81, then req[7] dropped mid-grant: SHALL grant 7 first, release on the drop, then grant 0.
REQ-033 Reset mid-grant with rst=1 during GRANT of index 3: SHALL give gnt_valid=0 and bcode=8'h00 next cycle; the following arbitration with req=8'h08 grants 3.
